alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-stage issue and capture unit for the 64-bit pipelined RISC-V core. It accepts decoded operations from ID/EX over a valid/ready handshake and translates the main-control ALU class plus funct fields into the 4-bit ALU operation code. It drives the ALU's A, B and op inputs from an internal issue register, then captures the ALU result and zero flag into an EX/MEM output register with branch resolution. The block is the producer and consumer end of the ALU interface and supports backpressure and flush.

## Interface
- Parameters:
- `XLEN`, 64, operand and result width.
- `TAGW`, 5, destination-register tag width.
- Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  kills both internal stages this cycle.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  stage can accept an operation.
- `in_a`, `in_b`  in  XLEN  operands.
- `in_class`  in  2  main-control ALU class: 00 mem, 01 branch, 10 R-type, 11 reserved.
- `in_funct3`  in  3  instruction funct3.
- `in_f7b30`  in  1  instruction bit 30.
- `in_tag`  in  TAGW  destination tag, passed through.
- `alu_a`, `alu_b`  out  XLEN  ALU operands, driven from the issue register.
- `alu_op`  out  4  ALU operation code.
- `alu_r`  in  XLEN  ALU result, combinational from `alu_*`.
- `alu_z`  in  1  ALU zero flag.
- `out_valid`  out  1  EX/MEM entry valid.
- `out_ready`  in  1  downstream accepts the entry.
- `out_r`  out  XLEN  captured result.
- `out_tag`  out  TAGW  captured tag.
- `out_branch`  out  1  entry is a branch.
- `out_taken`  out  1  branch resolved taken.
- `out_illegal`  out  1  unsupported encoding.

## Operation
- ALU op codes: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100.
- Decode:
  - Class 00 → ADD.
  - Class 01 → SUB. `funct3` 000 (beq) is taken when `alu_z`=1. `funct3` 001 (bne) is taken when `alu_z`=0. Any other `funct3` → illegal, not taken.
  - Class 10: 000/0 → ADD, 000/1 → SUB, 111/0 → AND, 110/0 → OR. Any other combination → illegal.
  - Class 11 → illegal.
  - Every illegal entry issues op ADD.
- Stage S1 (issue register) holds a, b, op, tag, branch kind, illegal flag and `s1_valid`. While `s1_valid`=0, S1 drives op 0010 and holds its last operands.
- Stage S2 (output register) captures `alu_r` into `out_r`. It captures the branch resolution from `alu_z` and passes through tag, branch and illegal.
- Advance rules:
  - `s2_adv` = `s1_valid` & (!`out_valid` | `out_ready`).
  - `in_ready` = !`s1_valid` | `s2_adv`.
  - S1 loads when `in_valid` & `in_ready`.
  - S2 clears `out_valid` when `out_ready` and no `s2_adv`.
- `out_taken` is 0 whenever `out_branch` is 0.
- `flush`:
  - Clears `s1_valid` and `out_valid` at the next edge.
  - Takes priority over a same-cycle accept; the accepted input is dropped.
  - `in_ready` still follows the normal rule during `flush`.
- Reset values: `out_valid`, `out_r`, `out_tag`, `out_branch`, `out_taken`, `out_illegal` = 0. `alu_a`, `alu_b` = 0. `alu_op` = 0010. `s1_valid` = 0.
- Reset mid-stream discards all in-flight entries. `in_ready`=1 in the first cycle after reset.

## Timing
- Accept at edge N: `alu_*` valid after edge N. Result is in `out_*` with `out_valid`=1 after edge N+1. Latency is 2 edges.
- Throughput is one operation per cycle while `out_ready`=1.
- `out_ready`=0 with both stages full:
  - `in_ready`=0.
  - S1 holds, so `alu_*` stay stable and the ALU output remains consistent.
  - `out_*` hold.
- Simultaneous S2 drain and S1 refill in one cycle is lossless.
- `out_*` are stable while `out_valid` & !`out_ready`.

## Configuration
- `ALU_NOR_EN` defined: class 10 with `funct3` 100 and `in_f7b30`=1 decodes to NOR (1100) and is not illegal.
- `ALU_NOR_EN` undefined: that encoding is illegal and issues ADD. Op code 1100 is never driven.

## Test plan
- Reset with `in_valid`=1 → all outputs at reset values. First accept occurs only after `reset` drops.
- Class 10, `funct3` 000, `f7b30`=1, a=10, b=3, `out_ready`=1 → `alu_op`=0110 one edge after accept. `out_r`=7 with `out_valid` two edges after accept.
- Class 01 beq with a=b=0x55 → `out_branch`=1, `out_taken`=1. bne with the same operands → `out_taken`=0.
- Back-to-back ops ADD(1,2), AND(0xF0,0x3C), OR(1,2), then `out_ready`=0 for 3 cycles → `in_ready` drops with two entries held and no loss. Outputs drain in order 3, 0x30, 3.
- `flush` in the same cycle as an accept, with S1 and S2 full → next cycle `out_valid`=0, and the flushed tags never appear.
- Class 10, `funct3` 100, `f7b30`=1, a=0, b=0 → with `ALU_NOR_EN`: `alu_op`=1100, `out_r`=all ones, `out_illegal`=0. Without `ALU_NOR_EN`: `alu_op`=0010, `out_illegal`=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage ALU issue/capture unit.
// S1 (issue register) decodes the ALU class and funct fields into a 4-bit ALU
// op and drives the external ALU. S2 (EX/MEM register) captures the ALU result,
// the zero flag and the branch resolution. Both stages use valid/ready flow
// control, and flush kills both stages.
// Build option: define ALU_NOR_EN to decode class 10 / funct3 100 / bit30=1 as NOR.
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [1:0]      in_class,
  input  logic [2:0]      in_funct3,
  input  logic            in_f7b30,
  input  logic [TAGW-1:0] in_tag,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_r,
  output logic [TAGW-1:0] out_tag,
  output logic            out_branch,
  output logic            out_taken,
  output logic            out_illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
`ifdef ALU_NOR_EN
  localparam logic [3:0] OP_NOR = 4'b1100;
`endif

  logic [3:0]      dec_op;
  logic            dec_br;
  logic            dec_bne;
  logic            dec_ill;

  logic            s1_valid;
  logic [3:0]      s1_op;
  logic [TAGW-1:0] s1_tag;
  logic            s1_br;
  logic            s1_bne;
  logic            s1_ill;

  logic            s2_adv;
  logic            s1_load;
  logic            s1_taken;

  // Decode main-control class and funct fields; illegal encodings issue ADD.
  always_comb begin
    dec_op  = OP_ADD;
    dec_br  = 1'b0;
    dec_bne = 1'b0;
    dec_ill = 1'b0;
    case (in_class)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        dec_op = OP_SUB;
        dec_br = 1'b1;
        case (in_funct3)
          3'b000:  dec_bne = 1'b0;
          3'b001:  dec_bne = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        case ({in_funct3, in_f7b30})
          4'b000_0: dec_op = OP_ADD;
          4'b000_1: dec_op = OP_SUB;
          4'b111_0: dec_op = OP_AND;
          4'b110_0: dec_op = OP_OR;
`ifdef ALU_NOR_EN
          4'b100_1: dec_op = OP_NOR;
`endif
          default:  dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op = OP_ADD;
    end
  end

  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign s1_load  = in_valid & in_ready;

  // An empty issue register presents ADD but keeps its last operands.
  assign alu_op   = s1_valid ? s1_op : OP_ADD;

  // Illegal branch encodings never resolve taken.
  assign s1_taken = s1_br & ~s1_ill & (s1_bne ? ~alu_z : alu_z);

  // S1 issue register; flush wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      s1_op    <= OP_ADD;
      s1_tag   <= '0;
      s1_br    <= 1'b0;
      s1_bne   <= 1'b0;
      s1_ill   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_load && !flush) begin
        alu_a  <= in_a;
        alu_b  <= in_b;
        s1_op  <= dec_op;
        s1_tag <= in_tag;
        s1_br  <= dec_br;
        s1_bne <= dec_bne;
        s1_ill <= dec_ill;
      end
    end
  end

  // S2 EX/MEM register; holds while stalled, drains when downstream accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_r       <= '0;
      out_tag     <= '0;
      out_branch  <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid   <= 1'b1;
      out_r       <= alu_r;
      out_tag     <= s1_tag;
      out_branch  <= s1_br;
      out_taken   <= s1_taken;
      out_illegal <= s1_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a queue scoreboard and an
// independent output monitor. The external ALU is modelled behaviourally.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b;
  logic [1:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_f7b30;
  logic [4:0]  in_tag;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_r;
  logic        alu_z;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_r;
  logic [4:0]  out_tag;
  logic        out_branch, out_taken, out_illegal;

  typedef struct packed {
    logic [63:0] r;
    logic [4:0]  tag;
    logic        br;
    logic        tk;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(64), .TAGW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_class(in_class), .in_funct3(in_funct3),
    .in_f7b30(in_f7b30), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
    .out_branch(out_branch), .out_taken(out_taken), .out_illegal(out_illegal)
  );

  // Behavioural ALU; unknown op codes give a marker value.
  always_comb begin
    alu_r = 64'hDEAD_BEEF_DEAD_BEEF;
    case (alu_op)
      4'b0000: alu_r = alu_a & alu_b;
      4'b0001: alu_r = alu_a | alu_b;
      4'b0010: alu_r = alu_a + alu_b;
      4'b0110: alu_r = alu_a - alu_b;
      4'b1100: alu_r = ~(alu_a | alu_b);
      default: ;
    endcase
  end
  assign alu_z = (alu_r == 64'd0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every delivered entry against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output_tag", {59'd0, out_tag}, 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_r", out_r, e.r);
        chk("out_tag", {59'd0, out_tag}, {59'd0, e.tag});
        chk("out_branch", {63'd0, out_branch}, {63'd0, e.br});
        chk("out_taken", {63'd0, out_taken}, {63'd0, e.tk});
        chk("out_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
      end
    end
  end

  // Stall monitor: outputs must hold while valid and not accepted.
  logic        held = 1'b0;
  logic [63:0] held_r;
  logic [4:0]  held_tag;
  always @(negedge clk) begin
    if (held && !reset) begin
      chk("hold_out_r", out_r, held_r);
      chk("hold_out_tag", {59'd0, out_tag}, {59'd0, held_tag});
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    held     = out_valid && !out_ready && !reset;
    held_r   = out_r;
    held_tag = out_tag;
  end

  task automatic issue(input logic [1:0] c, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tg,
                       input logic [63:0] er, input logic eb, input logic et, input logic ei);
    int n;
    exp_t e;
    in_valid  = 1'b1;
    in_class  = c;
    in_funct3 = f3;
    in_f7b30  = f7;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    end else begin
      e.r = er; e.tag = tg; e.br = eb; e.tk = et; e.ill = ei;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_remaining", 64'(sb.size()), 64'd0);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_a = 64'd9; in_b = 64'd9; in_class = 2'b10;
    in_funct3 = 3'b111; in_f7b30 = 1'b0; in_tag = 5'd31;

    // Reset with a valid input pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_r", out_r, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_out_flags", {61'd0, out_branch, out_taken, out_illegal}, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op}, 64'd2);
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_alu_op", {60'd0, alu_op}, 64'd2);
    chk("post_rst_alu_a", alu_a, 64'd0);
    @(posedge clk);
    #1;

    // SUB 10-3 with latency check.
    issue(2'b10, 3'b000, 1'b1, 64'd10, 64'd3, 5'd1, 64'd7, 1'b0, 1'b0, 1'b0);
    chk("sub_alu_op", {60'd0, alu_op}, 64'h6);
    chk("sub_alu_a", alu_a, 64'd10);
    chk("sub_out_valid_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("sub_out_valid", {63'd0, out_valid}, 64'd1);
    chk("sub_out_r", out_r, 64'd7);
    drain();

    // Branches: beq taken, bne not taken, on equal operands.
    issue(2'b01, 3'b000, 1'b0, 64'h55, 64'h55, 5'd2, 64'd0, 1'b1, 1'b1, 1'b0);
    issue(2'b01, 3'b001, 1'b0, 64'h55, 64'h55, 5'd3, 64'd0, 1'b1, 1'b0, 1'b0);
    // bne on unequal operands is taken.
    issue(2'b01, 3'b001, 1'b0, 64'h56, 64'h55, 5'd11, 64'd1, 1'b1, 1'b1, 1'b0);
    drain();

    // Back-to-back ADD, AND, OR then a 3-cycle downstream stall.
    issue(2'b10, 3'b000, 1'b0, 64'd1, 64'd2, 5'd4, 64'd3, 1'b0, 1'b0, 1'b0);
    issue(2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C, 5'd5, 64'h30, 1'b0, 1'b0, 1'b0);
    issue(2'b10, 3'b110, 1'b0, 64'd1, 64'd2, 5'd6, 64'd3, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_tag", {59'd0, out_tag}, 64'd5);
      chk("stall_alu_op", {60'd0, alu_op}, 64'd1);
      chk("stall_alu_a", alu_a, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Flush with both stages full and a same-cycle accept.
    out_ready = 1'b0;
    issue(2'b00, 3'b010, 1'b0, 64'd5, 64'd5, 5'd8, 64'd10, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 3'b010, 1'b0, 64'd6, 64'd6, 5'd9, 64'd12, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_class = 2'b00; in_a = 64'd7; in_b = 64'd7; in_tag = 5'd10;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_alu_op", {60'd0, alu_op}, 64'd2);
    chk("flush_in_ready_after", {63'd0, in_ready}, 64'd1);
    repeat (4) @(posedge clk);
    #1;

    // Class 00 ADD and reserved class 11.
    issue(2'b00, 3'b011, 1'b1, 64'd100, 64'd23, 5'd12, 64'd123, 1'b0, 1'b0, 1'b0);
    issue(2'b11, 3'b000, 1'b0, 64'd2, 64'd3, 5'd13, 64'd5, 1'b0, 1'b0, 1'b1);
    chk("cls11_alu_op", {60'd0, alu_op}, 64'd2);
    drain();

    // Optional NOR encoding.
`ifdef ALU_NOR_EN
    issue(2'b10, 3'b100, 1'b1, 64'd0, 64'd0, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("nor_alu_op", {60'd0, alu_op}, 64'hC);
`else
    issue(2'b10, 3'b100, 1'b1, 64'd0, 64'd0, 5'd14, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("nor_alu_op", {60'd0, alu_op}, 64'd2);
`endif
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
